flex_updown_counter: RTL and testbench

FLEX_UPDOWN_COUNTER -- requirements
Module: flex_updown_counter

---
 rtl/flex_updown_counter.sv | 122 ++++++++++++
 tb/tb_flex_updown_counter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_updown_counter.sv
// Purpose: parameterised up/down counter with wrap or saturate at a programmable bound, plus a saturating wrap-event counter.
// Latency: one cycle from any input to the registered outputs; there is no combinational input-to-output path.
// Backpressure: none; a step is taken on every cycle with count_enable high, and clear and load take precedence over it.
//
// Ports:
//   clk, n_rst          rising-edge clock, asynchronous active-low reset (all outputs forced to 0)
//   clear               synchronous clear of count, flags and wrap_count (highest priority)
//   load_enable/load_val synchronous load of count_out (second priority; wrap_count untouched)
//   count_enable        take one step this cycle (third priority)
//   count_up            direction: 1 = up toward rollover_val, 0 = down toward 1
//   sat_mode            1 = stick at the terminal value, 0 = wrap around
//   rollover_val        upper bound of the count range (unsigned)
//   count_out           registered count
//   rollover_flag       high while count_out sits at the terminal value
//   rollover_pulse      one-cycle strobe when a step arrives at the terminal value
//   wrap_count          number of rollover_pulse events, saturating at all-ones
module flex_updown_counter #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int WRAP_CNT_BITS = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     clear,
    input  logic                     load_enable,
    input  logic [NUM_CNT_BITS-1:0]  load_val,
    input  logic                     count_enable,
    input  logic                     count_up,
    input  logic                     sat_mode,
    input  logic [NUM_CNT_BITS-1:0]  rollover_val,
    output logic [NUM_CNT_BITS-1:0]  count_out,
    output logic                     rollover_flag,
    output logic                     rollover_pulse,
    output logic [WRAP_CNT_BITS-1:0] wrap_count
);

    typedef logic [NUM_CNT_BITS-1:0]  cnt_t;
    typedef logic [WRAP_CNT_BITS-1:0] wrap_t;

    localparam cnt_t  CNT_ONE  = cnt_t'(1);
    localparam wrap_t WRAP_ONE = wrap_t'(1);
    localparam wrap_t WRAP_MAX = '1;

    cnt_t  term_val;
    cnt_t  step_val;
    logic  step_at_term;
    cnt_t  next_cnt;
    logic  next_flag;
    logic  next_pulse;
    wrap_t next_wrap;

    // Terminal value: the bound when counting up, 1 when counting down.
    assign term_val = count_up ? rollover_val : CNT_ONE;

    // Value one enabled step would produce. The ">=" / "<=" comparisons let
    // a count that was loaded above the bound fall back into range, and
    // because the up increment only happens below rollover_val it can never
    // overflow past all-ones.
    always_comb begin
        step_val = count_out;
        if (rollover_val == '0) begin
            step_val = '0;
        end else if (count_up) begin
            if (count_out >= rollover_val) begin
                step_val = sat_mode ? rollover_val : CNT_ONE;
            end else begin
                step_val = count_out + CNT_ONE;
            end
        end else begin
            if (count_out <= CNT_ONE) begin
                step_val = sat_mode ? count_out : rollover_val;
            end else begin
                step_val = count_out - CNT_ONE;
            end
        end
    end

    // A zero bound is a degenerate range: the count parks at 0 and never
    // reports a terminal hit, even though 0 == term_val when counting up.
    assign step_at_term = (rollover_val != '0) && (step_val == term_val);

    always_comb begin
        next_cnt   = count_out;
        next_flag  = rollover_flag;
        next_pulse = 1'b0;
        next_wrap  = wrap_count;

        if (clear) begin
            next_cnt  = '0;
            next_flag = 1'b0;
            next_wrap = '0;
        end else if (load_enable) begin
            next_cnt  = load_val;
            next_flag = (load_val == term_val);
        end else if (count_enable) begin
            next_cnt   = step_val;
            next_flag  = step_at_term;
            // Only an arrival counts; sitting saturated at the terminal
            // value must not re-fire the strobe.
            next_pulse = step_at_term && (step_val != count_out);
        end

        // wrap_count advances on the same edge that registers the pulse.
        if (!clear && next_pulse && (wrap_count != WRAP_MAX)) begin
            next_wrap = wrap_count + WRAP_ONE;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out      <= '0;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
            wrap_count     <= '0;
        end else begin
            count_out      <= next_cnt;
            rollover_flag  <= next_flag;
            rollover_pulse <= next_pulse;
            wrap_count     <= next_wrap;
        end
    end

endmodule

// File: tb/tb_flex_updown_counter.sv
// Purpose: directed self-checking bench for flex_updown_counter (NUM_CNT_BITS=4, WRAP_CNT_BITS=8).
// Latency: each tick drives inputs, waits for one rising edge, and samples the registered outputs 1 ns later.
// Backpressure: not applicable; stimulus is a fixed sequence of directed vectors.
module tb_flex_updown_counter;

    logic       clk;
    logic       n_rst;
    logic       clear;
    logic       load_enable;
    logic [3:0] load_val;
    logic       count_enable;
    logic       count_up;
    logic       sat_mode;
    logic [3:0] rollover_val;
    logic [3:0] count_out;
    logic       rollover_flag;
    logic       rollover_pulse;
    logic [7:0] wrap_count;

    int n_checks;
    int n_fail;

    flex_updown_counter #(
        .NUM_CNT_BITS (4),
        .WRAP_CNT_BITS(8)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .load_enable   (load_enable),
        .load_val      (load_val),
        .count_enable  (count_enable),
        .count_up      (count_up),
        .sat_mode      (sat_mode),
        .rollover_val  (rollover_val),
        .count_out     (count_out),
        .rollover_flag (rollover_flag),
        .rollover_pulse(rollover_pulse),
        .wrap_count    (wrap_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: wait for the rising edge, then settle 1 ns before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " count"}, 32'(count_out), 32'd0);
        check({tag, " flag"},  32'(rollover_flag), 32'd0);
        check({tag, " pulse"}, 32'(rollover_pulse), 32'd0);
        check({tag, " wrap"},  32'(wrap_count), 32'd0);
    endtask

    task automatic check_step(input string tag, input logic [3:0] c, input logic f, input logic p);
        check({tag, " count"}, 32'(count_out), 32'(c));
        check({tag, " flag"},  32'(rollover_flag), 32'(f));
        check({tag, " pulse"}, 32'(rollover_pulse), 32'(p));
    endtask

    logic [3:0] up_cnt  [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd1};
    logic       up_flg  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] dn_cnt  [4] = '{4'd2, 4'd1, 4'd3, 4'd2};
    logic       dn_flg  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0] sat_cnt [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4};
    logic       sat_flg [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       sat_pls [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        n_rst        = 1'b0;
        clear        = 1'b0;
        load_enable  = 1'b0;
        load_val     = 4'd0;
        count_enable = 1'b0;
        count_up     = 1'b1;
        sat_mode     = 1'b0;
        rollover_val = 4'd5;

        #1;
        check_all_zero("reset");
        tick();
        n_rst = 1'b1;

        // Up count, wrap mode: pulse and flag coincide with the count at 5.
        count_enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_step($sformatf("upwrap%0d", i), up_cnt[i], up_flg[i], up_flg[i]);
        end
        check("upwrap wrap_count", 32'(wrap_count), 32'd1);

        // Asynchronous reset while holding count 7.
        count_enable = 1'b0;
        load_enable  = 1'b1;
        load_val     = 4'd7;
        tick();
        load_enable  = 1'b0;
        check("midreset pre count", 32'(count_out), 32'd7);
        #2;
        n_rst = 1'b0;
        #1;
        check_all_zero("midreset now");
        count_enable = 1'b1;
        tick();
        tick();
        check_all_zero("midreset held");
        n_rst = 1'b1;
        tick();
        check_step("post release", 4'd1, 1'b0, 1'b0);

        // Down count, wrap mode.
        count_enable = 1'b0;
        load_enable  = 1'b1;
        load_val     = 4'd3;
        count_up     = 1'b0;
        rollover_val = 4'd3;
        tick();
        check_step("dn load", 4'd3, 1'b0, 1'b0);
        load_enable  = 1'b0;
        count_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_step($sformatf("dnwrap%0d", i), dn_cnt[i], dn_flg[i], dn_flg[i]);
        end
        check("dnwrap wrap_count", 32'(wrap_count), 32'd1);

        // Up count, saturate mode.
        count_enable = 1'b0;
        clear        = 1'b1;
        tick();
        clear        = 1'b0;
        check_all_zero("clear");
        count_up     = 1'b1;
        sat_mode     = 1'b1;
        rollover_val = 4'd4;
        count_enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check_step($sformatf("upsat%0d", i), sat_cnt[i], sat_flg[i], sat_pls[i]);
        end
        check("upsat wrap_count", 32'(wrap_count), 32'd1);

        // Idle with changed direction and bound: flag must not re-evaluate.
        count_enable = 1'b0;
        count_up     = 1'b0;
        rollover_val = 4'd9;
        tick();
        check_step("idle hold", 4'd4, 1'b1, 1'b0);

        // Priority: clear beats load and enable.
        clear        = 1'b1;
        load_enable  = 1'b1;
        load_val     = 4'd9;
        count_enable = 1'b1;
        tick();
        check_step("prio clear", 4'd0, 1'b0, 1'b0);
        check("prio clear wrap", 32'(wrap_count), 32'd0);

        // Load beats enable, and may exceed the bound.
        clear        = 1'b0;
        count_up     = 1'b1;
        sat_mode     = 1'b0;
        rollover_val = 4'd15;
        tick();
        check_step("prio load", 4'd9, 1'b0, 1'b0);

        // Bound shrinks below the count: next up step falls back to 1.
        load_enable  = 1'b0;
        rollover_val = 4'd5;
        tick();
        check_step("shrink", 4'd1, 1'b0, 1'b0);

        // Zero bound parks the count at 0 with no flag.
        rollover_val = 4'd0;
        tick();
        check_step("zero bound", 4'd0, 1'b0, 1'b0);

        // All-ones bound: up step from 15 goes to 1, no overflow.
        count_enable = 1'b0;
        rollover_val = 4'd15;
        load_enable  = 1'b1;
        load_val     = 4'd15;
        tick();
        check_step("ones load", 4'd15, 1'b1, 1'b0);
        load_enable  = 1'b0;
        count_enable = 1'b1;
        tick();
        check_step("ones step", 4'd1, 1'b0, 1'b0);

        // Down saturate: arrival at 1 pulses once, then holds.
        count_enable = 1'b0;
        load_enable  = 1'b1;
        load_val     = 4'd2;
        count_up     = 1'b0;
        sat_mode     = 1'b1;
        rollover_val = 4'd5;
        tick();
        load_enable  = 1'b0;
        count_enable = 1'b1;
        tick();
        check_step("dnsat arrive", 4'd1, 1'b1, 1'b1);
        tick();
        check_step("dnsat hold", 4'd1, 1'b1, 1'b0);
        check("dnsat wrap", 32'(wrap_count), 32'd1);

        // wrap_count saturation: 300 load-0/step pairs with a bound of 1.
        count_enable = 1'b0;
        clear        = 1'b1;
        tick();
        clear        = 1'b0;
        count_up     = 1'b1;
        sat_mode     = 1'b0;
        rollover_val = 4'd1;
        load_val     = 4'd0;
        for (int i = 0; i < 300; i++) begin
            load_enable  = 1'b1;
            count_enable = 1'b0;
            tick();
            load_enable  = 1'b0;
            count_enable = 1'b1;
            tick();
        end
        count_enable = 1'b0;
        check("wrap sat", 32'(wrap_count), 32'd255);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("wrap cleared", 32'(wrap_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
